run_len_detector: RTL and testbench
===================================

# run_len_detector

Parametrised run-length detector on a single-bit serial input, sampled once per enabled clock. It tracks the current run of identical bits and flags runs of zeros or ones that reach a runtime-programmable threshold. Outputs are either level (held while the run persists) or a one-cycle pulse, and separate saturating event counters track zero-run and one-run detections. It replaces the fixed four-in-a-row Moore detector in the serial-input path; thr=4 with mode=0 reproduces that detector's behaviour.

## Interface
- CW, 3: run-length counter width; MAX_RUN = 2^CW-1.
- EW, 8: event counter width; saturates at 2^EW-1.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- en  in  1  sample strobe; `in` consumed only when en=1.
- in  in  1  serial data bit.
- mode  in  1  0 = level outputs, 1 = pulse outputs.
- thr  in  CW  run threshold; thr=0 treated as 1 (thr_eff).
- clr  in  1  synchronous clear of ev0/ev1 only.
- out  out  1  out0 | out1.
- out0  out  1  zero-run detect.
- out1  out  1  one-run detect.
- run_val  out  1  bit value of the current run.
- run_len  out  CW  length of the current run, 0 = no history.
- ev0  out  EW  count of zero-run detection events.
- ev1  out  EW  count of one-run detection events.

## Operation
- Registers: run_val, run_len, hit (pulse flag), ev0, ev1.
- Reset: run_val=0, run_len=0, hit=0, ev0=0, ev1=0. All outputs read 0.
- On en=1, compute the new state:
  - If run_len≠0 and in==run_val, then new_len = min(run_len+1, MAX_RUN). The run length saturates and never wraps.
  - Otherwise new_len=1 and new_val=in. This covers the first sample after reset and any bit change.
- Detection event (evt): en=1, new_len==thr_eff, and (new_len≠run_len or new_val≠run_val).
  - Saturated runs never re-trigger.
  - With thr_eff=1, every bit change is an event.
- hit is loaded with evt on every clock, so it is 0 on en=0 cycles.
- Level mode (mode=0): out0 = (run_val==0 && run_len≥thr_eff); out1 = (run_val==1 && run_len≥thr_eff).
- Pulse mode (mode=1): out0 = hit && run_val==0; out1 = hit && run_val==1.
- All outputs are Moore: combinational from registers plus live thr/mode, with no direct path from `in`.
- Event counters:
  - On evt, increment ev0 when new_val=0, or ev1 when new_val=1.
  - Counters hold at their all-ones value.
  - Counting is independent of mode.
- Priority: reset > clr > count.
  - If clr and evt occur together, the counter reads 0 next cycle; the event is dropped.
  - clr does not affect the run state or hit.
- en=0: run_val, run_len and ev* hold; hit clears.
- thr changed mid-run:
  - Level outputs re-evaluate immediately against the held run_len.
  - No pulse or event is generated unless a later sample lands exactly on the new thr_eff.
- thr>MAX_RUN is impossible given the CW width. thr=MAX_RUN detects saturated runs once.

## Timing
- Latency: `in` sampled at edge k; run_len, run_val and outputs reflect it after edge k, i.e. in cycle k+1.
- Pulse width: exactly one clock per event, even if en stays high.
- Reset asserted mid-run: state clears at the next edge and outputs are 0 the cycle after. The first sample after reset starts a run of length 1.
- No handshake; en may toggle every cycle; back-to-back events are supported.

## Test plan
- Legacy check, mode=0, thr=4: reset, then in=0 x4 with en=1 -> out0=1 after the 4th edge. A 5th 0 keeps out0=1 and ev0=1. in=1 -> out0=0, run_len=1, run_val=1.
- Ones run in pulse mode, mode=1, thr=3, CW=3: in=1 x9 -> out1 high for exactly one cycle after the 3rd edge. run_len saturates at 7. ev1=1 with no re-pulse.
- thr=0 / thr=1 with alternating bits 0,1,0,1 -> evt on every sample. ev0=2, ev1=2. In pulse mode out pulses every cycle.
- en gaps: thr=4, pattern 0,(en=0 x3),0,0,0 -> detection only after the 4th enabled 0. State holds through the gap; hit=0 during the gap.
- clr collision and counter saturation:
  - EW=2: 4 zero-run events -> ev0=3, held.
  - clr asserted on the same edge as an event -> ev0=0.
- Reset mid-run: thr=4, three 1s then reset -> run_len=0, outputs 0. Four further 1s are needed to assert out1. thr raised from 2 to 5 mid-run at run_len=3 -> out1 drops in the same cycle.

Source files
------------

// File: rtl/run_len_detector.sv
// Run-length detector on a serial bit stream: flags zero/one runs that reach a
// programmable threshold, with level or pulse outputs and saturating event counters.
module run_len_detector #(
    parameter int unsigned CW = 3,
    parameter int unsigned EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          in,
    input  logic          mode,
    input  logic [CW-1:0] thr,
    input  logic          clr,
    output logic          out,
    output logic          out0,
    output logic          out1,
    output logic          run_val,
    output logic [CW-1:0] run_len,
    output logic [EW-1:0] ev0,
    output logic [EW-1:0] ev1
);

    localparam logic [CW-1:0] MAX_RUN = {CW{1'b1}};
    localparam logic [EW-1:0] EV_MAX  = {EW{1'b1}};

    logic          hit;
    logic          val_nxt;
    logic [CW-1:0] len_nxt;
    logic          hit_nxt;
    logic [EW-1:0] ev0_nxt;
    logic [EW-1:0] ev1_nxt;

    logic [CW-1:0] thr_eff;
    logic          new_val;
    logic [CW-1:0] new_len;
    logic          evt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            run_val <= 1'b0;
            run_len <= '0;
            hit     <= 1'b0;
            ev0     <= '0;
            ev1     <= '0;
        end else begin
            run_val <= val_nxt;
            run_len <= len_nxt;
            hit     <= hit_nxt;
            ev0     <= ev0_nxt;
            ev1     <= ev1_nxt;
        end
    end

    // Candidate run state for the current sample; saturates instead of wrapping
    always_comb begin
        thr_eff = (thr == '0) ? CW'(1) : thr;
        new_val = in;
        new_len = CW'(1);
        if (run_len != '0 && in == run_val) begin
            new_val = run_val;
            new_len = (run_len == MAX_RUN) ? MAX_RUN : run_len + CW'(1);
        end
        evt = en && (new_len == thr_eff) &&
              ((new_len != run_len) || (new_val != run_val));
    end

    // Next-state logic; clr beats a same-cycle event
    always_comb begin
        val_nxt = run_val;
        len_nxt = run_len;
        hit_nxt = evt;
        ev0_nxt = ev0;
        ev1_nxt = ev1;
        if (en) begin
            val_nxt = new_val;
            len_nxt = new_len;
        end
        if (clr) begin
            ev0_nxt = '0;
            ev1_nxt = '0;
        end else if (evt) begin
            if (!new_val && ev0 != EV_MAX) ev0_nxt = ev0 + EW'(1);
            if (new_val && ev1 != EV_MAX)  ev1_nxt = ev1 + EW'(1);
        end
    end

    // Moore outputs from registered state plus live thr/mode
    always_comb begin
        out0 = 1'b0;
        out1 = 1'b0;
        if (mode) begin
            out0 = hit && !run_val;
            out1 = hit && run_val;
        end else begin
            out0 = !run_val && (run_len >= thr_eff);
            out1 = run_val && (run_len >= thr_eff);
        end
        out = out0 | out1;
    end

endmodule

// File: tb/tb_run_len_detector.sv
// Directed bench for run_len_detector (CW=3, EW=2 so counter saturation is reachable).
module tb_run_len_detector;

    localparam int unsigned CW = 3;
    localparam int unsigned EW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          in = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] thr = '0;
    logic          clr = 1'b0;
    logic          out, out0, out1, run_val;
    logic [CW-1:0] run_len;
    logic [EW-1:0] ev0, ev1;

    int vectors = 0;
    int miscompares = 0;

    run_len_detector #(.CW(CW), .EW(EW)) dut (
        .clk(clk), .reset(reset), .en(en), .in(in), .mode(mode), .thr(thr),
        .clr(clr), .out(out), .out0(out0), .out1(out1), .run_val(run_val),
        .run_len(run_len), .ev0(ev0), .ev1(ev1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus and sample #1 after the edge
    task automatic step(input logic e, input logic b);
        en = e;
        in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_len", run_len, 0);
        check("rst_val", run_val, 0);
        check("rst_out", {out, out0, out1}, 0);
        check("rst_ev", {ev0, ev1}, 0);

        // Legacy four-zeros detector
        mode = 1'b0; thr = 3'd4;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("leg_out0_%0d", i), out0, (i == 4) ? 1 : 0);
        end
        check("leg_out", out, 1);
        check("leg_len4", run_len, 4);
        step(1'b1, 1'b0);
        check("leg_out0_5", out0, 1);
        check("leg_ev0", ev0, 1);
        check("leg_len5", run_len, 5);
        step(1'b1, 1'b1);
        check("leg_out0_chg", out0, 0);
        check("leg_len_chg", run_len, 1);
        check("leg_val_chg", run_val, 1);

        // Ones run, pulse mode, saturation without re-pulse
        do_reset();
        mode = 1'b1; thr = 3'd3;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("pls_out1_%0d", i), out1, (i == 3) ? 1 : 0);
            check($sformatf("pls_len_%0d", i), run_len, (i > 7) ? 7 : i);
        end
        check("pls_ev1", ev1, 1);
        check("pls_ev0", ev0, 0);

        // thr=0 acts as 1: every bit change is an event
        do_reset();
        mode = 1'b1; thr = 3'd0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'(i % 2));
            check($sformatf("t0_out0_%0d", i), out0, (i % 2 == 0) ? 1 : 0);
            check($sformatf("t0_out1_%0d", i), out1, (i % 2 == 1) ? 1 : 0);
        end
        check("t0_ev0", ev0, 2);
        check("t0_ev1", ev1, 2);

        // en gaps hold state and clear hit
        do_reset();
        mode = 1'b1; thr = 3'd4;
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("gap_len_%0d", i), run_len, 1);
            check($sformatf("gap_val_%0d", i), run_val, 0);
            check($sformatf("gap_out_%0d", i), out, 0);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("gap_out0_3", out0, 0);
        step(1'b1, 1'b0);
        check("gap_out0_4", out0, 1);
        check("gap_len_4", run_len, 4);
        step(1'b0, 1'b0);
        check("gap_hitclr", out0, 0);
        check("gap_len_hold", run_len, 4);
        check("gap_ev0", ev0, 1);

        // Counter saturation at 3, then clr colliding with an event
        do_reset();
        mode = 1'b0; thr = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
        end
        check("sat_ev0", ev0, 3);
        check("sat_ev1", ev1, 3);
        clr = 1'b1;
        mode = 1'b1;
        step(1'b1, 1'b0);
        clr = 1'b0;
        check("clr_ev0", ev0, 0);
        check("clr_ev1", ev1, 0);
        check("clr_len", run_len, 1);
        check("clr_val", run_val, 0);
        check("clr_hit", out0, 1);

        // Reset mid-run
        do_reset();
        mode = 1'b0; thr = 3'd4;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("mid_len3", run_len, 3);
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        check("mid_rst_len", run_len, 0);
        check("mid_rst_out", out, 0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("mid_out1_%0d", i), out1, (i == 4) ? 1 : 0);
        end

        // thr raised mid-run drops level output without a clock edge
        do_reset();
        mode = 1'b0; thr = 3'd2;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("thr_out1_pre", out1, 1);
        thr = 3'd5;
        #1;
        check("thr_out1_drop", out1, 0);
        check("thr_ev1_pre", ev1, 1);
        step(1'b1, 1'b1);
        check("thr_out1_len4", out1, 0);
        step(1'b1, 1'b1);
        check("thr_out1_len5", out1, 1);
        check("thr_ev1_post", ev1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
